// File: rtl/axi_stream_header_inserter.sv
`default_nettype none
// ============================================================================
// Module  : axi_stream_header_inserter
// Brief   : Prepends a 0..DATA_BYTE_WD byte header to each AXI-Stream packet,
//           repacking header and payload bytes MSB-first into full beats.
// Revision: 1.0 - initial release
// ============================================================================
module axi_stream_header_inserter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD:0]    byte_insert_cnt,
  output logic                    ready_insert
);

  localparam logic [BYTE_CNT_WD:0] c_BYTES  = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);
  localparam int                   c_SUM_WD = BYTE_CNT_WD + 2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DATA     = 2'd1,
    S_FLUSH    = 2'd2,
    S_WAIT_END = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BYTE_CNT_WD:0]    r_hdr_cnt;
  logic [BYTE_CNT_WD:0]    r_tail_cnt;
  logic [DATA_WD-1:0]      r_held;
  logic                    r_valid_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;
  logic                    r_last_out;

  logic [DATA_WD-1:0]      w_keep_bits;
  logic [DATA_WD-1:0]      w_data_masked;
  logic [BYTE_CNT_WD:0]    w_m_cnt;
  logic [BYTE_CNT_WD:0]    w_rem_cnt;
  logic [BYTE_CNT_WD:0]    w_tail_cnt;
  logic [BYTE_CNT_WD:0]    w_ins_cnt;
  logic [c_SUM_WD-1:0]     w_sum;
  logic                    w_fits;
  logic [DATA_WD-1:0]      w_beat_data;
  logic [DATA_WD-1:0]      w_beat_held;
  logic [DATA_WD-1:0]      w_flush_data;
  logic                    w_out_free;
  logic                    w_load;
  logic [DATA_WD-1:0]      w_load_data;
  logic [DATA_BYTE_WD-1:0] w_load_keep;
  logic                    w_load_last;
  logic                    w_take_hdr;
  logic                    w_take_beat;
  logic                    w_ready_in;
  logic                    w_ready_insert;
  logic                    w_unused_keep_insert;

  // Left-aligned keep with k ones (k may exceed the beat width).
  function automatic logic [DATA_BYTE_WD-1:0] f_top_ones(input logic [c_SUM_WD-1:0] k);
    f_top_ones = ~({DATA_BYTE_WD{1'b1}} >> k);
  endfunction

  function automatic logic [DATA_WD-1:0] f_low_bytes(input logic [BYTE_CNT_WD:0] n);
    f_low_bytes = ~({DATA_WD{1'b1}} << {n, 3'b000});
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_keep_bits
      assign w_keep_bits[gi*8 +: 8] = {8{keep_in[gi]}};
    end
  endgenerate

  always_comb begin
    w_m_cnt = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      w_m_cnt = w_m_cnt + (BYTE_CNT_WD + 1)'(keep_in[i]);
    end
  end

  // Invalid payload bytes are zeroed up front so padding never leaks out.
  assign w_data_masked = data_in & w_keep_bits;
  assign w_sum         = {1'b0, w_m_cnt} + {1'b0, r_hdr_cnt};
  assign w_fits        = (w_sum <= {1'b0, c_BYTES});
  assign w_tail_cnt    = w_m_cnt + r_hdr_cnt - c_BYTES;
  assign w_rem_cnt     = c_BYTES - r_hdr_cnt;
  assign w_ins_cnt     = (byte_insert_cnt > c_BYTES) ? c_BYTES : byte_insert_cnt;
  assign w_beat_data   = (r_held << {w_rem_cnt, 3'b000}) | (w_data_masked >> {r_hdr_cnt, 3'b000});
  assign w_beat_held   = w_data_masked & f_low_bytes(r_hdr_cnt);
  assign w_flush_data  = r_held << {w_rem_cnt, 3'b000};
  assign w_out_free    = ~r_valid_out | ready_out;

  assign w_unused_keep_insert = ^keep_insert;

  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_load_data    = '0;
    w_load_keep    = '0;
    w_load_last    = 1'b0;
    w_take_hdr     = 1'b0;
    w_take_beat    = 1'b0;
    w_ready_in     = 1'b0;
    w_ready_insert = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready_insert = 1'b1;
        if (valid_insert) begin
          w_take_hdr  = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_ready_in = w_out_free;
        if (valid_in && w_out_free) begin
          w_take_beat = 1'b1;
          w_load      = 1'b1;
          w_load_data = w_beat_data;
          w_load_keep = '1;
          if (last_in) begin
            if (w_fits) begin
              w_load_keep = f_top_ones(w_sum);
              w_load_last = 1'b1;
              w_state_nxt = S_WAIT_END;
            end else begin
              w_state_nxt = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_load_data = w_flush_data;
          w_load_keep = f_top_ones({1'b0, r_tail_cnt});
          w_load_last = 1'b1;
          w_state_nxt = S_WAIT_END;
        end
      end
      S_WAIT_END: begin
        if (w_out_free) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_cnt  <= '0;
      r_tail_cnt <= '0;
      r_held     <= '0;
    end else if (w_take_hdr) begin
      r_hdr_cnt <= w_ins_cnt;
      r_held    <= data_insert & f_low_bytes(w_ins_cnt);
    end else if (w_take_beat) begin
      r_held     <= w_beat_held;
      r_tail_cnt <= w_tail_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_keep_out  <= '0;
      r_last_out  <= 1'b0;
    end else if (w_load) begin
      r_valid_out <= 1'b1;
      r_data_out  <= w_load_data;
      r_keep_out  <= w_load_keep;
      r_last_out  <= w_load_last;
    end else if (ready_out) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_keep_out  <= '0;
      r_last_out  <= 1'b0;
    end
  end

  assign ready_in     = w_ready_in;
  assign ready_insert = w_ready_insert & rst_n;
  assign valid_out    = r_valid_out;
  assign data_out     = r_data_out;
  assign keep_out     = r_keep_out;
  assign last_out     = r_last_out;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_header_inserter.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_stream_header_inserter
// Brief   : Vector table, corner sequences and randomized packets vs byte model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_stream_header_inserter;
  localparam int BOUND = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        valid_insert = 1'b0;
  logic [31:0] data_insert = '0;
  logic [3:0]  keep_insert = '0;
  logic [2:0]  byte_insert_cnt = '0;
  logic        ready_insert;

  axi_stream_header_inserter #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    int               n;
    logic [31:0]      hdr;
    int               nin;
    logic [0:3][31:0] din;
    logic [3:0]       lkeep;
    int               nout;
    logic [0:3][31:0] dout;
    logic [0:3][3:0]  kout;
  } vec_t;

  int    total = 0;
  int    bad = 0;
  bit    stall_en = 1'b0;
  beat_t rx_q[$];
  beat_t exp_q[$];
  vec_t  vt[7];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: handshake timed out after %0d cycles", name, BOUND);
  endtask

  initial begin
    ready_out = 1'b1;
    forever begin
      @(negedge clk);
      ready_out = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: collects transfers and checks stalled beats stay frozen.
  initial begin
    beat_t prev;
    bit    prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("hold", {valid_out, last_out, keep_out, data_out}, {1'b1, prev.l, prev.k, prev.d});
        prev.d = data_out;
        prev.k = keep_out;
        prev.l = last_out;
        prev_stall = valid_out && !ready_out;
        if (valid_out && ready_out) rx_q.push_back(prev);
      end
    end
  end

  task automatic drive_hdr(input int n, input logic [31:0] hdr);
    int t;
    bit hs;
    t = 0;
    @(negedge clk);
    valid_insert    = 1'b1;
    data_insert     = hdr;
    byte_insert_cnt = 3'(n);
    keep_insert     = 4'((1 << n) - 1);
    forever begin
      #1 hs = ready_insert;
      @(posedge clk);
      if (hs) break;
      t++;
      if (t > BOUND) begin
        timeout_fail("hdr_handshake");
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    valid_insert    = 1'b0;
    data_insert     = $urandom;
    byte_insert_cnt = 3'($urandom);
    keep_insert     = '0;
  endtask

  task automatic drive_data(input logic [31:0] beats[$], input logic [3:0] lkeep, input bit gaps);
    foreach (beats[i]) begin
      int t;
      bit hs;
      bit is_last;
      t = 0;
      is_last = (i == beats.size() - 1);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          valid_in = 1'b0;
          data_in  = $urandom;
        end
      end
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = beats[i];
      keep_in  = is_last ? lkeep : 4'hF;
      last_in  = is_last;
      forever begin
        #1 hs = valid_in && ready_in;
        @(posedge clk);
        if (hs) break;
        t++;
        if (t > BOUND) begin
          timeout_fail("data_handshake");
          break;
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    last_in  = 1'b0;
    data_in  = $urandom;
    keep_in  = 4'($urandom);
  endtask

  // Reference: header bytes then payload bytes as one byte list, chopped into beats.
  function automatic void model(input int n, input logic [31:0] hdr, input logic [31:0] beats[$],
                                input int m);
    logic [7:0] bq[$];
    for (int i = n - 1; i >= 0; i--) bq.push_back(hdr[8*i +: 8]);
    foreach (beats[b]) begin
      int          cnt;
      logic [31:0] w;
      w   = beats[b];
      cnt = (b == beats.size() - 1) ? m : 4;
      for (int j = 0; j < cnt; j++) bq.push_back(w[31-8*j -: 8]);
    end
    while (bq.size() > 0) begin
      beat_t e;
      e.d = '0;
      e.k = '0;
      for (int j = 0; j < 4; j++) begin
        if (bq.size() > 0) begin
          e.d[31-8*j -: 8] = bq.pop_front();
          e.k[3-j] = 1'b1;
        end
      end
      e.l = (bq.size() == 0);
      exp_q.push_back(e);
    end
  endfunction

  task automatic run_and_check(input string name, input int n, input logic [31:0] hdr,
                               input logic [31:0] beats[$], input logic [3:0] lkeep, input bit gaps);
    int    t;
    int    cnt;
    beat_t e;
    beat_t a;
    t   = 0;
    cnt = exp_q.size();
    fork
      drive_hdr(n, hdr);
      drive_data(beats, lkeep, gaps);
    join
    while (rx_q.size() < cnt && t < BOUND) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    check({name, "_beats"}, rx_q.size(), cnt);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) begin
        a = rx_q.pop_front();
      end else begin
        a.d = 'x;
        a.k = 'x;
        a.l = 1'bx;
      end
      check(name, {a.l, a.k, a.d}, {e.l, e.k, e.d});
    end
    rx_q.delete();
  endtask

  initial begin
    logic [31:0] bq[$];

    vt[0] = '{2, 32'h0000AABB, 2, {32'h11223344, 32'h55667788, 32'h0, 32'h0}, 4'b1100,
              2, {32'hAABB1122, 32'h33445566, 32'h0, 32'h0}, {4'hF, 4'hF, 4'h0, 4'h0}};
    vt[1] = '{3, 32'h00AABBCC, 1, {32'h11223344, 32'h0, 32'h0, 32'h0}, 4'b1100,
              2, {32'hAABBCC11, 32'h22000000, 32'h0, 32'h0}, {4'hF, 4'h8, 4'h0, 4'h0}};
    vt[2] = '{4, 32'hDEADBEEF, 1, {32'h12345678, 32'h0, 32'h0, 32'h0}, 4'b1000,
              2, {32'hDEADBEEF, 32'h12000000, 32'h0, 32'h0}, {4'hF, 4'h8, 4'h0, 4'h0}};
    vt[3] = '{0, 32'h12345678, 2, {32'hCAFEF00D, 32'h01020304, 32'h0, 32'h0}, 4'b1110,
              2, {32'hCAFEF00D, 32'h01020300, 32'h0, 32'h0}, {4'hF, 4'hE, 4'h0, 4'h0}};
    vt[4] = '{1, 32'hFFFFFF99, 1, {32'hA1A2A3A4, 32'h0, 32'h0, 32'h0}, 4'b1111,
              2, {32'h99A1A2A3, 32'hA4000000, 32'h0, 32'h0}, {4'hF, 4'h8, 4'h0, 4'h0}};
    vt[5] = '{2, 32'h77770102, 1, {32'h10203040, 32'h0, 32'h0, 32'h0}, 4'b1000,
              1, {32'h01021000, 32'h0, 32'h0, 32'h0}, {4'hE, 4'h0, 4'h0, 4'h0}};
    vt[6] = '{4, 32'h01020304, 2, {32'hAABBCCDD, 32'hEEFF0011, 32'h0, 32'h0}, 4'b1111,
              3, {32'h01020304, 32'hAABBCCDD, 32'hEEFF0011, 32'h0}, {4'hF, 4'hF, 4'hF, 4'h0}};

    // reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_outputs", {valid_out, last_out, keep_out, data_out}, '0);
    check("rst_ready_in", ready_in, 1'b0);
    check("rst_ready_insert", ready_insert, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_ready_insert", ready_insert, 1'b1);
    check("idle_ready_in", ready_in, 1'b0);

    for (int v = 0; v < 7; v++) begin
      bq.delete();
      for (int i = 0; i < vt[v].nin; i++) bq.push_back(vt[v].din[i]);
      for (int i = 0; i < vt[v].nout; i++) begin
        beat_t e;
        e.d = vt[v].dout[i];
        e.k = vt[v].kout[i];
        e.l = (i == vt[v].nout - 1);
        exp_q.push_back(e);
      end
      run_and_check($sformatf("vec%0d", v), vt[v].n, vt[v].hdr, bq, vt[v].lkeep, 1'b0);
    end

    // vector 0 again with sink back-pressure and source gaps
    stall_en = 1'b1;
    bq.delete();
    bq.push_back(32'h11223344);
    bq.push_back(32'h55667788);
    exp_q.push_back('{32'hAABB1122, 4'hF, 1'b0});
    exp_q.push_back('{32'h33445566, 4'hF, 1'b1});
    run_and_check("stall_vec0", 2, 32'h0000AABB, bq, 4'b1100, 1'b1);
    stall_en = 1'b0;

    // payload offered before any header
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = 32'h11223344;
    keep_in  = 4'hF;
    last_in  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("pre_hdr_ready_in", ready_in, 1'b0);
      check("pre_hdr_valid_out", valid_out, 1'b0);
      check("pre_hdr_ready_insert", ready_insert, 1'b1);
    end
    valid_insert    = 1'b1;
    data_insert     = 32'h5555AABB;
    byte_insert_cnt = 3'd2;
    keep_insert     = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    valid_insert = 1'b0;
    #1;
    check("pkt_ready_insert", ready_insert, 1'b0);
    check("pkt_ready_in", ready_in, 1'b1);
    check("pkt_no_out_yet", valid_out, 1'b0);
    @(posedge clk);
    @(negedge clk);
    data_in = 32'h55667788;
    keep_in = 4'b1100;
    last_in = 1'b1;
    #1;
    check("first_latency", {valid_out, last_out, keep_out, data_out}, {1'b1, 1'b0, 4'hF, 32'hAABB1122});
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    last_in  = 1'b0;
    #1;
    check("second_beat", {valid_out, last_out, keep_out, data_out}, {1'b1, 1'b1, 4'hF, 32'h33445566});
    check("wait_ready_insert", ready_insert, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("back_idle_ready_insert", ready_insert, 1'b1);
    check("back_idle_valid_out", valid_out, 1'b0);
    rx_q.delete();

    // asynchronous reset in the middle of a packet
    @(negedge clk);
    valid_insert    = 1'b1;
    data_insert     = 32'h0000AABB;
    byte_insert_cnt = 3'd2;
    keep_insert     = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    valid_insert = 1'b0;
    valid_in     = 1'b1;
    data_in      = 32'h11223344;
    keep_in      = 4'hF;
    last_in      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    check("mid_pkt_valid_out", valid_out, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {valid_out, last_out, keep_out, data_out}, '0);
    check("mid_rst_ready_in", ready_in, 1'b0);
    check("mid_rst_ready_insert", ready_insert, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    bq.delete();
    bq.push_back(32'h11223344);
    bq.push_back(32'h55667788);
    model(2, 32'h0000AABB, bq, 2);
    run_and_check("after_reset", 2, 32'h0000AABB, bq, 4'b1100, 1'b0);

    // randomized packets against the byte-stream model
    for (int p = 0; p < 40; p++) begin
      int          n;
      int          nb;
      int          m;
      logic [31:0] hdr;
      n   = $urandom_range(0, 4);
      nb  = $urandom_range(1, 4);
      m   = $urandom_range(1, 4);
      hdr = $urandom;
      stall_en = 1'($urandom_range(0, 1));
      bq.delete();
      repeat (nb) bq.push_back($urandom);
      model(n, hdr, bq, m);
      run_and_check($sformatf("rand%0d", p), n, hdr, bq, 4'(4'hF << (4 - m)),
                    1'($urandom_range(0, 1)));
    end
    stall_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
